seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 185 ++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// Walks the four digit slots, holding each anode dark for a short dead time
// at the start of every slot, and feeds the matching BCD nibble to a
// downstream segment encoder. Input digits are double-buffered so that a
// displayed frame never mixes old and new values, and leading zeros can
// be blanked.
module seg_scan_driver #(
    parameter int CLK_DIV = 100000,
    parameter int DEAD    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic        lz_en,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        pending,
    output logic        frame_done
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);

    // Scan state
    logic          r_run;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_active;
    logic [15:0]   r_shadow;
    logic          r_pending;
    logic          r_frame_done;
    logic [3:0]    r_an;
    logic [3:0]    r_bcd;

    // Next-state values
    logic          w_run_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_idx_nxt;
    logic [15:0]   w_active_nxt;
    logic [15:0]   w_shadow_nxt;
    logic          w_pending_nxt;
    logic          w_fd_nxt;
    logic [3:0]    w_an_nxt;
    logic [3:0]    w_bcd_nxt;

    logic          w_slot_end;
    logic          w_wrap;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic          w_z3;
    logic          w_z2;
    logic          w_z1;

    assign w_slot_end = (r_cnt == CNT_MAX);
    // The 3 -> 0 slot transition is the frame boundary; buffers swap only here.
    assign w_wrap     = r_run && enable && w_slot_end && (r_idx == 2'd3);

    // Slot counter, digit index and double-buffer control.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_run_nxt     = r_run;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_active_nxt  = r_active;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_fd_nxt      = 1'b0;

        if (!enable) begin
            // Display is dark, so new data can go straight to the active buffer.
            w_run_nxt     = 1'b0;
            w_cnt_nxt     = '0;
            w_idx_nxt     = 2'd0;
            w_pending_nxt = 1'b0;
            if (load)
                w_active_nxt = digits;
            else if (r_pending)
                w_active_nxt = r_shadow;
        end else if (!r_run) begin
            // First enabled cycle: start slot 0 cleanly, no frame pulse.
            w_run_nxt = 1'b1;
            w_cnt_nxt = '0;
            w_idx_nxt = 2'd0;
            if (load) begin
                w_shadow_nxt  = digits;
                w_pending_nxt = 1'b1;
            end
        end else begin
            if (w_slot_end) begin
                w_cnt_nxt = '0;
                w_idx_nxt = r_idx + 2'd1;
                w_fd_nxt  = (r_idx == 2'd3);
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end

            if (w_wrap) begin
                w_pending_nxt = 1'b0;
                if (load)
                    w_active_nxt = digits;
                else if (r_pending)
                    w_active_nxt = r_shadow;
            end else if (load && r_frame_done) begin
                // Still inside slot 0 dead time, so the whole frame shows it.
                w_active_nxt = digits;
            end else if (load) begin
                w_shadow_nxt  = digits;
                w_pending_nxt = 1'b1;
            end
        end
    end

    // Leading-zero blanking and anode/nibble decode for the upcoming cycle.
    always_comb begin
        w_z3 = (w_active_nxt[15:12] == 4'h0);
        w_z2 = (w_active_nxt[11:8]  == 4'h0);
        w_z1 = (w_active_nxt[7:4]   == 4'h0);
        w_nib   = w_active_nxt[3:0];
        w_blank = 1'b0;
        case (w_idx_nxt)
            2'd3: begin
                w_nib   = w_active_nxt[15:12];
                w_blank = w_z3;
            end
            2'd2: begin
                w_nib   = w_active_nxt[11:8];
                w_blank = w_z3 && w_z2;
            end
            2'd1: begin
                w_nib   = w_active_nxt[7:4];
                w_blank = w_z3 && w_z2 && w_z1;
            end
            default: begin
                w_nib   = w_active_nxt[3:0];
                w_blank = 1'b0;
            end
        endcase
        w_blank = w_blank && lz_en;

        w_an_nxt  = 4'b1111;
        w_bcd_nxt = 4'hF;
        if (enable) begin
            w_bcd_nxt = w_blank ? 4'hF : w_nib;
            if (!w_blank && (w_cnt_nxt >= DEAD_CNT))
                w_an_nxt = ~(4'b0001 << w_idx_nxt);
        end
    end

    // State and registered outputs, all updated together so they stay consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run        <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_active     <= 16'h0000;
            r_shadow     <= 16'h0000;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_an         <= 4'b1111;
            r_bcd        <= 4'hF;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_run        <= w_run_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_active     <= w_active_nxt;
            r_shadow     <= w_shadow_nxt;
            r_pending    <= w_pending_nxt;
            r_frame_done <= w_fd_nxt;
            r_an         <= w_an_nxt;
            r_bcd        <= w_bcd_nxt;
        end
    end

    assign an         = r_an;
    assign bcd_out    = r_bcd;
    assign digit_idx  = r_idx;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with CLK_DIV=8, DEAD=2.
// Each driven cycle pushes the expected output word onto a scoreboard queue;
// the word is popped and compared once the DUT has produced that cycle.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        pending;
    logic        frame_done;

    seg_scan_driver #(.CLK_DIV(8), .DEAD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .digits     (digits),
        .load       (load),
        .lz_en      (lz_en),
        .bcd_out    (bcd_out),
        .an         (an),
        .digit_idx  (digit_idx),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [11:0] sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Bench-side scan phase of the cycle most recently checked.
    logic        p_run = 1'b0;
    logic [2:0]  p_cnt = 3'd0;
    logic [1:0]  p_idx = 2'd0;
    logic        last_fd = 1'b0;

    localparam logic [11:0] DARK_WORD = {4'hF, 4'hF, 2'd0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed an=%b bcd=%h idx=%0d pend=%b fd=%b, expected an=%b bcd=%h idx=%0d pend=%b fd=%b",
                     tag, obs[11:8], obs[7:4], obs[3:2], obs[1], obs[0],
                     exp[11:8], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [11:0] observed();
        return {an, bcd_out, digit_idx, pending, frame_done};
    endfunction

    // Expected outputs for one scan cycle, written from the display rules.
    function automatic logic [11:0] pattern(input logic [2:0] cnt, input logic [1:0] idx,
                                            input logic [15:0] v, input logic lz,
                                            input logic pend, input logic fd);
        logic [3:0] nib;
        logic [3:0] a;
        logic [3:0] b;
        logic       blank;
        logic       z3, z2, z1;
        nib = v[idx*4 +: 4];
        z3 = (v[15:12] == 4'd0);
        z2 = (v[11:8] == 4'd0);
        z1 = (v[7:4] == 4'd0);
        case (idx)
            2'd3:    blank = z3;
            2'd2:    blank = z3 && z2;
            2'd1:    blank = z3 && z2 && z1;
            default: blank = 1'b0;
        endcase
        blank = blank && lz;
        a = 4'b1111;
        if (cnt >= 3'd2 && !blank) a[idx] = 1'b0;
        b = blank ? 4'hF : nib;
        return {a, b, idx, pend, fd};
    endfunction

    function automatic logic next_is_boundary();
        return p_run && (p_cnt == 3'd7) && (p_idx == 2'd3);
    endfunction

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic cyc(input logic en, input logic ld, input logic [15:0] d, input logic lz,
                       input logic [15:0] shown, input logic pend_e, input string tag);
        logic [11:0] exp_w;
        logic [11:0] got_w;
        logic        fd;
        fd = 1'b0;
        if (!en) begin
            p_run = 1'b0; p_cnt = 3'd0; p_idx = 2'd0;
        end else if (!p_run) begin
            p_run = 1'b1; p_cnt = 3'd0; p_idx = 2'd0;
        end else if (p_cnt == 3'd7) begin
            p_cnt = 3'd0;
            p_idx = p_idx + 2'd1;
            fd = (p_idx == 2'd0);
        end else begin
            p_cnt = p_cnt + 3'd1;
        end
        if (!en) exp_w = {4'hF, 4'hF, 2'd0, pend_e, 1'b0};
        else     exp_w = pattern(p_cnt, p_idx, shown, lz, pend_e, fd);
        last_fd = fd;
        sb_q.push_back(exp_w);
        enable = en; load = ld; digits = d; lz_en = lz;
        @(posedge clk);
        #1;
        load = 1'b0;
        got_w = observed();
        if (sb_q.size() == 0) check({tag, "_empty"}, got_w, ~got_w);
        else                  check(tag, got_w, sb_q.pop_front());
    endtask

    task automatic check_now(input string tag, input logic [11:0] exp);
        sb_q.push_back(exp);
        check(tag, observed(), sb_q.pop_front());
    endtask

    task automatic run(input int n, input logic lz, input logic [15:0] shown, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, lz, shown, 1'b0, tag);
    endtask

    task automatic wait_phase(input logic [1:0] idx, input logic [2:0] cnt, input logic lz,
                              input logic [15:0] shown, input logic pend, input string tag);
        for (int i = 0; i < 40 && !(p_idx == idx && p_cnt == cnt); i++)
            cyc(1'b1, 1'b0, 16'h0, lz, shown, pend, tag);
    endtask

    // Run until one full frame after the pending value lands at the boundary.
    task automatic run_swap(input logic [15:0] old_v, input logic [15:0] new_v, input string tag);
        logic sw;
        sw = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (next_is_boundary()) sw = 1'b1;
            cyc(1'b1, 1'b0, 16'h0, 1'b0, sw ? new_v : old_v, !sw, tag);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_now("reset", DARK_WORD);
        rst_n = 1'b1;

        // Basic scan of 1234: load while disabled goes straight to display
        cyc(1'b0, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, "dis_load");
        run(72, 1'b0, 16'h1234, "scan_1234");

        // Leading-zero suppression cases
        cyc(1'b0, 1'b1, 16'h0045, 1'b1, 16'h0, 1'b0, "dis_load");
        run(33, 1'b1, 16'h0045, "lz_0045");
        cyc(1'b0, 1'b1, 16'h0000, 1'b1, 16'h0, 1'b0, "dis_load");
        run(33, 1'b1, 16'h0000, "lz_0000");
        cyc(1'b0, 1'b1, 16'h0A0B, 1'b1, 16'h0, 1'b0, "dis_load");
        run(33, 1'b1, 16'h0A0B, "lz_0a0b");

        // Tearing: load during slot 1 shows only from the boundary on
        cyc(1'b0, 1'b1, 16'h1111, 1'b0, 16'h0, 1'b0, "dis_load");
        wait_phase(2'd1, 3'd3, 1'b0, 16'h1111, 1'b0, "pre_tear");
        cyc(1'b1, 1'b1, 16'h2222, 1'b0, 16'h1111, 1'b1, "tear_load");
        run_swap(16'h1111, 16'h2222, "tear");

        // Back-to-back loads: only the last one before the boundary is shown
        wait_phase(2'd1, 3'd5, 1'b0, 16'h2222, 1'b0, "pre_dbl");
        cyc(1'b1, 1'b1, 16'h4444, 1'b0, 16'h2222, 1'b1, "dbl_load1");
        wait_phase(2'd3, 3'd2, 1'b0, 16'h2222, 1'b1, "dbl_wait");
        cyc(1'b1, 1'b1, 16'h5555, 1'b0, 16'h2222, 1'b1, "dbl_load2");
        run_swap(16'h2222, 16'h5555, "dbl");

        // Load in the frame_done cycle applies to that frame directly
        for (int i = 0; i < 40 && !last_fd; i++)
            cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h5555, 1'b0, "pre_bnd");
        cyc(1'b1, 1'b1, 16'h5678, 1'b0, 16'h5678, 1'b0, "bnd_load");
        run(36, 1'b0, 16'h5678, "bnd_frame");

        // Enable drop mid slot 2 with a pending value, then resume
        wait_phase(2'd0, 3'd5, 1'b0, 16'h5678, 1'b0, "pre_drop");
        cyc(1'b1, 1'b1, 16'h9ABC, 1'b0, 16'h5678, 1'b1, "drop_load");
        wait_phase(2'd2, 3'd4, 1'b0, 16'h5678, 1'b1, "pre_drop");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, "en_drop");
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, "en_low");
        run(40, 1'b0, 16'h9ABC, "resume");

        // Async reset mid-cycle while a load is pending
        cyc(1'b1, 1'b1, 16'h1357, 1'b0, 16'h9ABC, 1'b1, "rst_load");
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_rst", DARK_WORD);
        p_run = 1'b0;
        @(posedge clk);
        #1;
        check_now("rst_hold", DARK_WORD);
        rst_n = 1'b1;
        run(40, 1'b0, 16'h0000, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
